// File: rtl/axis_join.sv
// axis_join: two-to-one AXI-Stream merger that strictly alternates between
// branch s01 and branch s00 (starting on s01). The output is registered and
// backed by a one-word skid register, so the slave treadys depend only on
// local flops and never on m_axis_tready.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   join_enable                1: toggle source after each accepted word
//   s00_axis_* / s01_axis_*    slave branches (tvalid, tdata, tready)
//   m_axis_*                   merged master stream (registered tvalid/tdata)
//   join_sel                   current source: 0 = s01, 1 = s00
//   join_count                 words accepted since reset (wraps)
module axis_join #(
  parameter int unsigned DATA_WD = 64,
  parameter int unsigned CNT_WD  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               join_enable,
  input  logic               s00_axis_tvalid,
  input  logic [DATA_WD-1:0] s00_axis_tdata,
  output logic               s00_axis_tready,
  input  logic               s01_axis_tvalid,
  input  logic [DATA_WD-1:0] s01_axis_tdata,
  output logic               s01_axis_tready,
  output logic               m_axis_tvalid,
  output logic [DATA_WD-1:0] m_axis_tdata,
  input  logic               m_axis_tready,
  output logic               join_sel,
  output logic [CNT_WD-1:0]  join_count
);

  logic               sel_q, sel_d;
  logic               run_q, run_d;
  logic               m_valid_q, m_valid_d;
  logic [DATA_WD-1:0] m_data_q, m_data_d;
  logic               skid_valid_q, skid_valid_d;
  logic [DATA_WD-1:0] skid_data_q, skid_data_d;
  logic [CNT_WD-1:0]  count_q, count_d;

  logic               rdy;
  logic               sel_valid;
  logic [DATA_WD-1:0] sel_data;
  logic               accept;
  logic               out_free;

  // Ready is purely register-derived; a full skid blocks both branches.
  assign rdy       = run_q & ~skid_valid_q;
  assign sel_valid = sel_q ? s00_axis_tvalid : s01_axis_tvalid;
  assign sel_data  = sel_q ? s00_axis_tdata  : s01_axis_tdata;
  assign accept    = rdy & sel_valid;
  assign out_free  = ~m_valid_q | m_axis_tready;

  // Next-state: source select, counter, output and skid registers.
  always_comb begin
    sel_d        = sel_q;
    run_d        = 1'b1;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    count_d      = count_q;

    if (accept) begin
      count_d = count_q + CNT_WD'(1);
      if (join_enable) begin
        sel_d = ~sel_q;
      end
    end

    if (out_free) begin
      if (skid_valid_q) begin
        // accept cannot coincide here since rdy is low while skid is full
        m_valid_d    = 1'b1;
        m_data_d     = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = sel_data;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = sel_data;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q        <= 1'b0;
      run_q        <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      count_q      <= '0;
    end else begin
      sel_q        <= sel_d;
      run_q        <= run_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      count_q      <= count_d;
    end
  end

  assign s00_axis_tready = rdy & sel_q;
  assign s01_axis_tready = rdy & ~sel_q;
  assign m_axis_tvalid   = m_valid_q;
  assign m_axis_tdata    = m_data_q;
  assign join_sel        = sel_q;
  assign join_count      = count_q;

endmodule

// File: tb/tb_axis_join.sv
// Bench for axis_join: queue-based occupancy model checked every cycle, plus
// directed scenarios with literal expectations on the output word order.
module tb_axis_join;

  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          join_enable = 1'b0;
  logic          s00_tvalid = 1'b0;
  logic [DW-1:0] s00_tdata = '0;
  logic          s00_tready;
  logic          s01_tvalid = 1'b0;
  logic [DW-1:0] s01_tdata = '0;
  logic          s01_tready;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tready = 1'b0;
  logic          join_sel;
  logic [31:0]   join_count;

  logic          s00_tready4, s01_tready4, m_tvalid4, join_sel4;
  logic [DW-1:0] m_tdata4;
  logic [3:0]    join_count4;

  always #5 clk = ~clk;

  axis_join #(.DATA_WD(DW), .CNT_WD(32)) dut (
    .clk(clk), .rst_n(rst_n), .join_enable(join_enable),
    .s00_axis_tvalid(s00_tvalid), .s00_axis_tdata(s00_tdata), .s00_axis_tready(s00_tready),
    .s01_axis_tvalid(s01_tvalid), .s01_axis_tdata(s01_tdata), .s01_axis_tready(s01_tready),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tready(m_tready),
    .join_sel(join_sel), .join_count(join_count)
  );

  // Narrow-counter instance sharing the same stimulus, used for wrap checks.
  axis_join #(.DATA_WD(DW), .CNT_WD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .join_enable(join_enable),
    .s00_axis_tvalid(s00_tvalid), .s00_axis_tdata(s00_tdata), .s00_axis_tready(s00_tready4),
    .s01_axis_tvalid(s01_tvalid), .s01_axis_tdata(s01_tdata), .s01_axis_tready(s01_tready4),
    .m_axis_tvalid(m_tvalid4), .m_axis_tdata(m_tdata4), .m_axis_tready(m_tready),
    .join_sel(join_sel4), .join_count(join_count4)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source branches: each offers the head of its queue.
  logic [DW-1:0] q00[$];
  logic [DW-1:0] q01[$];
  logic [DW-1:0] out_log[$];
  int cyc = 0;
  int first_acc = -1;
  int first_val = -1;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    logic hs0, hs1;
    forever begin
      @(negedge clk);
      hs0 = s00_tvalid && s00_tready;
      hs1 = s01_tvalid && s01_tready;
      if (hs1 && first_acc < 0) first_acc = cyc;
      @(posedge clk);
      #1;
      if (hs0 && q00.size() > 0) void'(q00.pop_front());
      if (hs1 && q01.size() > 0) void'(q01.pop_front());
      s00_tvalid = (q00.size() > 0);
      s00_tdata  = (q00.size() > 0) ? q00[0] : '0;
      s01_tvalid = (q01.size() > 0);
      s01_tdata  = (q01.size() > 0) ? q01[0] : '0;
    end
  end

  // Record every word delivered on the master side.
  always @(negedge clk) begin
    if (m_tvalid && m_tready) out_log.push_back(m_tdata);
    if (m_tvalid && first_val < 0) first_val = cyc;
  end

  // Model: the block holds at most two words (output + skid) in accept order.
  logic [DW-1:0] mq[$];
  logic          m_sel = 1'b0;
  logic          m_run = 1'b0;
  logic [31:0]   m_cnt = '0;
  logic [DW-1:0] m_last = '0;

  always @(posedge clk or negedge rst_n) begin
    logic acc;
    logic [DW-1:0] dat;
    if (!rst_n) begin
      mq.delete();
      m_sel  = 1'b0;
      m_run  = 1'b0;
      m_cnt  = '0;
      m_last = '0;
    end else begin
      acc = m_run && (mq.size() < 2) && (m_sel ? s00_tvalid : s01_tvalid);
      dat = m_sel ? s00_tdata : s01_tdata;
      if (mq.size() > 0 && m_tready) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(dat);
        m_cnt = m_cnt + 32'd1;
        if (join_enable) m_sel = ~m_sel;
      end
      if (mq.size() > 0) m_last = mq[0];
      m_run = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic rdy_e;
    rdy_e = m_run && (mq.size() < 2);
    chk("s00_tready", DW'(s00_tready), DW'(rdy_e && m_sel));
    chk("s01_tready", DW'(s01_tready), DW'(rdy_e && !m_sel));
    chk("m_tvalid", DW'(m_tvalid), DW'(mq.size() > 0));
    chk("m_tdata", m_tdata, (mq.size() > 0) ? mq[0] : m_last);
    chk("join_sel", DW'(join_sel), DW'(m_sel));
    chk("join_count", DW'(join_count), DW'(m_cnt));
    chk("join_count4", DW'(join_count4), DW'(m_cnt[3:0]));
  end

  task automatic wait_log(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (out_log.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    chk({name, "_timeout"}, DW'(out_log.size() >= n), DW'(1));
  endtask

  task automatic chk_log(input string name, input int idx, input logic [DW-1:0] exp);
    logic [DW-1:0] act;
    act = (idx < out_log.size()) ? out_log[idx] : 'x;
    chk(name, act, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: alternating merge starting on s01
    join_enable = 1'b1;
    m_tready = 1'b1;
    q01.push_back(64'hA0); q01.push_back(64'hA1);
    q00.push_back(64'hB0); q00.push_back(64'hB1);
    wait_log(4, 50, "t1");
    chk_log("t1_w0", 0, 64'hA0);
    chk_log("t1_w1", 1, 64'hB0);
    chk_log("t1_w2", 2, 64'hA1);
    chk_log("t1_w3", 3, 64'hB1);
    chk("t1_count", DW'(join_count), 64'd4);
    chk("t1_latency", DW'(first_val - first_acc), 64'd1);

    // 2: stall master mid-burst; skid absorbs one word
    out_log.delete();
    for (int i = 0; i < 4; i++) begin
      q01.push_back(64'hC0 + DW'(i));
      q00.push_back(64'hD0 + DW'(i));
    end
    repeat (3) @(posedge clk);
    #1 m_tready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t2_s00_stall", DW'(s00_tready), 64'd0);
    chk("t2_s01_stall", DW'(s01_tready), 64'd0);
    chk("t2_mvalid_stall", DW'(m_tvalid), 64'd1);
    @(posedge clk);
    #1 m_tready = 1'b1;
    wait_log(8, 100, "t2");
    for (int i = 0; i < 4; i++) begin
      chk_log("t2_even", 2 * i, 64'hC0 + DW'(i));
      chk_log("t2_odd", 2 * i + 1, 64'hD0 + DW'(i));
    end

    // 3: hold on s01 while s00 is valid
    out_log.delete();
    join_enable = 1'b0;
    q01.push_back(64'hE0); q01.push_back(64'hE1); q01.push_back(64'hE2);
    q00.push_back(64'hF0);
    wait_log(3, 50, "t3");
    chk_log("t3_w0", 0, 64'hE0);
    chk_log("t3_w1", 1, 64'hE1);
    chk_log("t3_w2", 2, 64'hE2);
    chk("t3_sel", DW'(join_sel), 64'd0);
    chk("t3_s00_tready", DW'(s00_tready), 64'd0);

    // 4: only s00 valid after reset -> block waits for s01
    @(posedge clk);
    #1 rst_n = 1'b0;
    q00.delete(); q01.delete(); out_log.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    join_enable = 1'b1;
    q00.push_back(64'h60);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t4_mvalid_idle", DW'(m_tvalid), 64'd0);
    chk("t4_log_empty", DW'(out_log.size()), 64'd0);
    q01.push_back(64'h70);
    wait_log(2, 50, "t4");
    chk_log("t4_w0", 0, 64'h70);
    chk_log("t4_w1", 1, 64'h60);

    // 5: reset with output and skid full
    out_log.delete();
    m_tready = 1'b0;
    q01.push_back(64'h80); q01.push_back(64'h81);
    q00.push_back(64'h90); q00.push_back(64'h91);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t5_full_mvalid", DW'(m_tvalid), 64'd1);
    chk("t5_full_tready", DW'(s00_tready | s01_tready), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_mvalid", DW'(m_tvalid), 64'd0);
    chk("t5_async_mdata", m_tdata, 64'd0);
    q00.delete(); q01.delete(); out_log.delete();
    q00.push_back(64'hAA); q01.push_back(64'hBB);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_run_s00", DW'(s00_tready), 64'd0);
    chk("t5_run_s01", DW'(s01_tready), 64'd0);
    chk("t5_sel", DW'(join_sel), 64'd0);
    chk("t5_count", DW'(join_count), 64'd0);
    m_tready = 1'b1;
    wait_log(2, 50, "t5");
    chk_log("t5_w0", 0, 64'hBB);
    chk_log("t5_w1", 1, 64'hAA);

    // 6: 17 accepts wrap the 4-bit counter to 1
    @(posedge clk);
    #1 rst_n = 1'b0;
    q00.delete(); q01.delete(); out_log.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 9; i++) q01.push_back(64'h100 + DW'(i));
    for (int i = 0; i < 8; i++) q00.push_back(64'h200 + DW'(i));
    wait_log(17, 200, "t6");
    chk("t6_count4", DW'(join_count4), 64'd1);
    chk("t6_count32", DW'(join_count), 64'd17);
    chk_log("t6_w0", 0, 64'h100);
    chk_log("t6_w1", 1, 64'h200);
    chk_log("t6_w16", 16, 64'h108);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
